// File: rtl/scalar_reg_arbiter.sv
// scalar_reg_arbiter: shares the single write port and single read port of
// scalar_regs among NUM_REQ requesters using two independent round-robin
// arbiters. Writes are registered one stage before reaching the register
// file. Read responses are registered, and an in-flight write to the same
// address is forwarded into the response.
module scalar_reg_arbiter #(
  parameter int WIDTH       = 16,
  parameter int NUM_SCALARS = 4,
  parameter int NUM_REQ     = 3,
  parameter int WADDR_W     = 4,
  parameter int RADDR_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           wr_valid,
  output logic [NUM_REQ-1:0]           wr_ready,
  input  logic [NUM_REQ*WADDR_W-1:0]   wr_addr,
  input  logic [NUM_REQ*WIDTH-1:0]     wr_data,
  input  logic [NUM_REQ-1:0]           rd_valid,
  output logic [NUM_REQ-1:0]           rd_ready,
  input  logic [NUM_REQ*RADDR_W-1:0]   rd_addr,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]             rsp_data,
  output logic                         err_addr,
  output logic                         rf_we,
  output logic [WADDR_W-1:0]           rf_write_addr,
  output logic [WIDTH-1:0]             rf_write_data,
  output logic [RADDR_W-1:0]           rf_read_addr,
  input  logic [WIDTH-1:0]             rf_read_data
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Round-robin pointers: the requester with highest priority next cycle
  logic [ID_W-1:0]    wr_ptr_q, rd_ptr_q;

  // Arbitration results
  logic               wr_found, rd_found;
  logic [ID_W-1:0]    wr_idx, rd_idx;
  logic [WADDR_W-1:0] wr_sel_addr;
  logic [WIDTH-1:0]   wr_sel_data;
  logic [RADDR_W-1:0] rd_sel_addr;
  int unsigned        wj, rj;

  // Write pipeline registers
  logic               rf_we_q;
  logic [WADDR_W-1:0] rf_write_addr_q;
  logic [WIDTH-1:0]   rf_write_data_q;
  logic               err_addr_q;
  logic               wr_in_range;

  // Read path registers
  logic [RADDR_W-1:0] rd_addr_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic [WIDTH-1:0]   rsp_data_d;
  logic               wr_hs, rd_hs;

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
    if (32'(idx) == 32'(NUM_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // Write arbiter: first valid requester at or after wr_ptr_q, with wrap
  always_comb begin
    wr_found    = 1'b0;
    wr_idx      = '0;
    wr_sel_addr = '0;
    wr_sel_data = '0;
    wj          = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      wj = (32'(wr_ptr_q) + i) % 32'(NUM_REQ);
      if (!wr_found && wr_valid[wj]) begin
        wr_found    = 1'b1;
        wr_idx      = ID_W'(wj);
        wr_sel_addr = wr_addr[wj*WADDR_W +: WADDR_W];
        wr_sel_data = wr_data[wj*WIDTH +: WIDTH];
      end
    end
  end

  // Read arbiter: same scheme with its own pointer
  always_comb begin
    rd_found    = 1'b0;
    rd_idx      = '0;
    rd_sel_addr = '0;
    rj          = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rj = (32'(rd_ptr_q) + i) % 32'(NUM_REQ);
      if (!rd_found && rd_valid[rj]) begin
        rd_found    = 1'b1;
        rd_idx      = ID_W'(rj);
        rd_sel_addr = rd_addr[rj*RADDR_W +: RADDR_W];
      end
    end
  end

  // One-hot grants, suppressed while reset is asserted
  always_comb begin
    wr_hs    = rst_n && wr_found;
    rd_hs    = rst_n && rd_found;
    wr_ready = '0;
    rd_ready = '0;
    if (wr_hs) wr_ready[wr_idx] = 1'b1;
    if (rd_hs) rd_ready[rd_idx] = 1'b1;
  end

  // Read address to the register file and response data with write bypass
  always_comb begin
    wr_in_range  = 32'(wr_sel_addr) < 32'(NUM_SCALARS);
    rf_read_addr = rd_found ? rd_sel_addr : rd_addr_q;
    if (rf_we_q && (32'(rf_write_addr_q) == 32'(rf_read_addr)))
      rsp_data_d = rf_write_data_q;
    else
      rsp_data_d = rf_read_data;
  end

  // Arbiter pointers advance past the granted requester
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_hs) wr_ptr_q <= ptr_after(wr_idx);
      if (rd_hs) rd_ptr_q <= ptr_after(rd_idx);
    end
  end

  // Write stage: register granted write, flag out-of-range addresses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q         <= 1'b0;
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
      err_addr_q      <= 1'b0;
    end else begin
      rf_we_q    <= wr_hs && wr_in_range;
      err_addr_q <= wr_hs && !wr_in_range;
      if (wr_hs) begin
        rf_write_addr_q <= wr_sel_addr;
        rf_write_data_q <= wr_sel_data;
      end
    end
  end

  // Read stage: hold last read address, register the response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_hs;
      if (rd_hs) begin
        rd_addr_q  <= rd_sel_addr;
        rsp_id_q   <= rd_idx;
        rsp_data_q <= rsp_data_d;
      end
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;
  assign err_addr      = err_addr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_data      = rsp_data_q;

endmodule
